// File: rtl/instr_seq_pkg.sv
// Shared types and constants for the instruction sequencer.
// Opcodes, state encoding, PC source and ALU op codes.
package instr_seq_pkg;

   localparam logic [3:0] OP_BR   = 4'b0000;
   localparam logic [3:0] OP_ADD  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0101;
   localparam logic [3:0] OP_NOT  = 4'b1001;
   localparam logic [3:0] OP_JMP  = 4'b1100;
   localparam logic [3:0] OP_TRAP = 4'b1111;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_PCUPD  = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      PC_INC  = 2'b00,
      PC_OFF9 = 2'b01,
      PC_REG  = 2'b10,
      PC_HOLD = 2'b11
   } pc_sel_t;

   typedef enum logic [1:0] {
      ALU_ADD  = 2'b00,
      ALU_AND  = 2'b01,
      ALU_NOT  = 2'b10,
      ALU_PASS = 2'b11
   } alu_op_t;

   typedef enum logic [2:0] {
      C_NOP, C_ADD, C_AND, C_NOT,
      C_BR, C_JMP, C_TRAP
   } op_cls_t;

   typedef struct packed {
      op_cls_t    cls;
      alu_op_t    alu_op;
      logic [2:0] dr;
      logic [2:0] sr1;
      logic [2:0] sr2;
      logic       imm_sel;
      logic [4:0] imm5;
      logic [8:0] off9;
      logic [2:0] nzp;
   } dec_t;

   // nzp=111 is unconditional, nzp=000 never branches
   function automatic pc_sel_t pc_sel_f(
      op_cls_t    cls,
      logic [2:0] nzp,
      logic       taken
   );
      pc_sel_f = PC_INC;
      if (cls == C_JMP) begin
         pc_sel_f = PC_REG;
      end else if (cls == C_BR) begin
         if (nzp == 3'b111)
            pc_sel_f = PC_OFF9;
         else if (nzp != 3'b000 && taken)
            pc_sel_f = PC_OFF9;
      end
   endfunction

endpackage

// File: rtl/instr_seq_if.sv
// Instruction memory fetch bus.
// master = sequencer, slave = instruction memory.
interface instr_seq_if #(
   parameter int INSTR_W = 16
) ();
   logic [INSTR_W-1:0] instr_in;
   logic               instr_valid_in;
   logic               instr_req_out;

   modport master (
      output instr_req_out,
      input  instr_in,
      input  instr_valid_in
   );

   modport slave (
      input  instr_req_out,
      output instr_in,
      output instr_valid_in
   );
endinterface

// File: rtl/instr_seq_decode.sv
// Combinational instruction decoder.
// Maps the instruction register to fields and opcode class.
module instr_decode
   import instr_seq_pkg::*;
(
   input  logic [15:0] ir,
   output dec_t        dec
);

   logic [3:0] op;

   assign op = ir[15:12];

   always_comb begin
      dec        = '0;
      dec.cls    = C_NOP;
      dec.alu_op = ALU_PASS;
      unique case (1'b1)
         (op == OP_ADD): begin
            dec.cls     = C_ADD;
            dec.alu_op  = ALU_ADD;
            dec.dr      = ir[11:9];
            dec.sr1     = ir[8:6];
            dec.imm_sel = ir[5];
            dec.imm5    = ir[4:0];
            dec.sr2     = ir[2:0];
         end
         (op == OP_AND): begin
            dec.cls     = C_AND;
            dec.alu_op  = ALU_AND;
            dec.dr      = ir[11:9];
            dec.sr1     = ir[8:6];
            dec.imm_sel = ir[5];
            dec.imm5    = ir[4:0];
            dec.sr2     = ir[2:0];
         end
         (op == OP_NOT): begin
            dec.cls    = C_NOT;
            dec.alu_op = ALU_NOT;
            dec.dr     = ir[11:9];
            dec.sr1    = ir[8:6];
         end
         (op == OP_BR): begin
            dec.cls  = C_BR;
            dec.nzp  = ir[11:9];
            dec.off9 = ir[8:0];
         end
         (op == OP_JMP): begin
            dec.cls = C_JMP;
            dec.sr1 = ir[8:6];
         end
         (op == OP_TRAP): begin
            dec.cls = C_TRAP;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/instr_seq.sv
// Multi-cycle instruction sequencer:
// IDLE -> FETCH -> DECODE -> EXEC -> PCUPD -> FETCH/HALT.
module instr_seq
   import instr_seq_pkg::*;
#(
   parameter int INSTR_W = 16
) (
   input  logic       clka,
   input  logic       reset_in,
   instr_seq_if.master imem,
   input  logic       pc_ctl_0_in,
   output logic [1:0] pc_sel_out,
   output logic       pc_latch_out,
   output logic       we_reg_out,
   output logic       br_out,
   output logic       n_dec_out,
   output logic       z_dec_out,
   output logic       p_dec_out,
   output logic [1:0] alu_op_out,
   output logic [2:0] dr_out,
   output logic [2:0] sr1_out,
   output logic [2:0] sr2_out,
   output logic       imm_sel_out,
   output logic [4:0] imm5_out,
   output logic [8:0] offset9_out,
   output logic       halt_out,
   output logic [2:0] state_out
);

   state_t             state_q;
   state_t             state_d;
   logic [INSTR_W-1:0] ir_q;
   dec_t               dec;
   logic               fields_on;
   logic               br_on;

   instr_decode u_dec (
      .ir  (ir_q),
      .dec (dec)
   );

   always_ff @(posedge clka or negedge reset_in) begin
      if (!reset_in) begin
         state_q <= S_IDLE;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_FETCH && imem.instr_valid_in)
            ir_q <= imem.instr_in;
      end
   end

   always_comb begin
      state_d = S_IDLE;
      unique case (state_q)
         S_IDLE:   state_d = S_FETCH;
         S_FETCH:  state_d = imem.instr_valid_in ? S_DECODE : S_FETCH;
         S_DECODE: state_d = S_EXEC;
         S_EXEC:   state_d = S_PCUPD;
         S_PCUPD:  state_d = (dec.cls == C_TRAP) ? S_HALT : S_FETCH;
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_IDLE;
      endcase
   end

   // Decoded fields are only visible while an instruction is in flight
   assign fields_on = (state_q == S_DECODE) || (state_q == S_EXEC) ||
                      (state_q == S_PCUPD);
   assign br_on     = ((state_q == S_EXEC) || (state_q == S_PCUPD)) &&
                      (dec.cls == C_BR);

   always_comb begin
      imem.instr_req_out = 1'b0;
      pc_sel_out   = PC_HOLD;
      pc_latch_out = 1'b0;
      we_reg_out   = 1'b0;
      br_out       = 1'b0;
      n_dec_out    = 1'b0;
      z_dec_out    = 1'b0;
      p_dec_out    = 1'b0;
      alu_op_out   = 2'b00;
      dr_out       = 3'd0;
      sr1_out      = 3'd0;
      sr2_out      = 3'd0;
      imm_sel_out  = 1'b0;
      imm5_out     = 5'd0;
      offset9_out  = 9'd0;
      halt_out     = 1'b0;
      if (fields_on) begin
         alu_op_out  = dec.alu_op;
         dr_out      = dec.dr;
         sr1_out     = dec.sr1;
         sr2_out     = dec.sr2;
         imm_sel_out = dec.imm_sel;
         imm5_out    = dec.imm5;
         offset9_out = dec.off9;
      end
      if (br_on) begin
         br_out    = 1'b1;
         n_dec_out = dec.nzp[2];
         z_dec_out = dec.nzp[1];
         p_dec_out = dec.nzp[0];
      end
      unique case (state_q)
         S_FETCH: imem.instr_req_out = 1'b1;
         S_EXEC:  we_reg_out = (dec.cls == C_ADD) ||
                               (dec.cls == C_AND) ||
                               (dec.cls == C_NOT);
         S_PCUPD: begin
            pc_latch_out = 1'b1;
            pc_sel_out   = pc_sel_f(dec.cls, dec.nzp, pc_ctl_0_in);
         end
         S_HALT:  halt_out = 1'b1;
         default: ;
      endcase
   end

   assign state_out = state_q;

endmodule

// File: tb/tb_instr_seq.sv
// Self-checking bench for instr_seq.
// Randomized instructions checked against a behavioural model.
module tb_instr_seq;

   logic       clka = 1'b0;
   logic       reset_in;
   logic       pc_ctl_0_in;
   logic [1:0] pc_sel_out;
   logic       pc_latch_out;
   logic       we_reg_out;
   logic       br_out;
   logic       n_dec_out;
   logic       z_dec_out;
   logic       p_dec_out;
   logic [1:0] alu_op_out;
   logic [2:0] dr_out;
   logic [2:0] sr1_out;
   logic [2:0] sr2_out;
   logic       imm_sel_out;
   logic [4:0] imm5_out;
   logic [8:0] offset9_out;
   logic       halt_out;
   logic [2:0] state_out;

   int n_chk  = 0;
   int n_fail = 0;

   instr_seq_if #(.INSTR_W(16)) bus ();

   instr_seq #(.INSTR_W(16)) dut (
      .clka         (clka),
      .reset_in     (reset_in),
      .imem         (bus),
      .pc_ctl_0_in  (pc_ctl_0_in),
      .pc_sel_out   (pc_sel_out),
      .pc_latch_out (pc_latch_out),
      .we_reg_out   (we_reg_out),
      .br_out       (br_out),
      .n_dec_out    (n_dec_out),
      .z_dec_out    (z_dec_out),
      .p_dec_out    (p_dec_out),
      .alu_op_out   (alu_op_out),
      .dr_out       (dr_out),
      .sr1_out      (sr1_out),
      .sr2_out      (sr2_out),
      .imm_sel_out  (imm_sel_out),
      .imm5_out     (imm5_out),
      .offset9_out  (offset9_out),
      .halt_out     (halt_out),
      .state_out    (state_out)
   );

   always #5 clka = ~clka;

   typedef struct {
      logic [2:0] st;
      logic       req, we, br, n, z, p, isel, latch, halt;
      logic [1:0] alu, psel;
      logic [2:0] dr, sr1, sr2;
      logic [4:0] imm5;
      logic [8:0] off9;
   } snap_t;

   snap_t sn [0:4];

   task automatic take(input int k);
      sn[k].st    = state_out;
      sn[k].req   = bus.instr_req_out;
      sn[k].we    = we_reg_out;
      sn[k].br    = br_out;
      sn[k].n     = n_dec_out;
      sn[k].z     = z_dec_out;
      sn[k].p     = p_dec_out;
      sn[k].isel  = imm_sel_out;
      sn[k].latch = pc_latch_out;
      sn[k].halt  = halt_out;
      sn[k].alu   = alu_op_out;
      sn[k].psel  = pc_sel_out;
      sn[k].dr    = dr_out;
      sn[k].sr1   = sr1_out;
      sn[k].sr2   = sr2_out;
      sn[k].imm5  = imm5_out;
      sn[k].off9  = offset9_out;
   endtask

   // Presents one instruction at a negedge in FETCH; snapshot k is
   // the k-th cycle after the accepting cycle (1=DECODE .. 4=next)
   task automatic run_instr(input logic [15:0] ins, input logic ctl,
                            input bit hold);
      bus.instr_in       = ins;
      bus.instr_valid_in = 1'b1;
      pc_ctl_0_in        = ctl;
      take(0);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clka);
         take(k);
         if (hold && k < 4) bus.instr_in = 16'($urandom);
         else bus.instr_valid_in = 1'b0;
      end
   endtask

   // Reference: expected PC source from the branch rules
   function automatic int exp_psel(int ins, bit ctl);
      int op, nzp;
      op  = (ins >> 12) & 15;
      nzp = (ins >> 9) & 7;
      if (op == 12) return 2;
      if (op != 0) return 0;
      if (nzp == 7) return 1;
      if (nzp == 0) return 0;
      return ctl ? 1 : 0;
   endfunction

   task automatic test_reset;
      reset_in = 1'b0;
      bus.instr_valid_in = 1'b0;
      bus.instr_in = 16'h0;
      pc_ctl_0_in = 1'b0;
      repeat (2) @(negedge clka);
      n_chk++; if (state_out !== 3'd0) begin n_fail++; $display("FAIL rst_state: got %0d want 0", state_out); end
      n_chk++; if (pc_sel_out !== 2'b11) begin n_fail++; $display("FAIL rst_pcsel: got %0d want 3", pc_sel_out); end
      n_chk++; if ({bus.instr_req_out, halt_out, we_reg_out, pc_latch_out, br_out} !== 5'b0) begin
         n_fail++; $display("FAIL rst_ctl: got %b want 00000", {bus.instr_req_out, halt_out, we_reg_out, pc_latch_out, br_out}); end
      reset_in = 1'b1;
      @(negedge clka);
      n_chk++; if (state_out !== 3'd1) begin n_fail++; $display("FAIL rst_release: got %0d want 1", state_out); end
      n_chk++; if (bus.instr_req_out !== 1'b1) begin n_fail++; $display("FAIL fetch_req: got %b want 1", bus.instr_req_out); end
   endtask

   task automatic test_reset_mid_exec;
      bus.instr_in = 16'h12A3;
      bus.instr_valid_in = 1'b1;
      @(posedge clka);
      @(negedge clka);
      bus.instr_valid_in = 1'b0;
      @(posedge clka);
      #2;
      n_chk++; if (we_reg_out !== 1'b1) begin n_fail++; $display("FAIL midx_we_pre: got %b want 1", we_reg_out); end
      reset_in = 1'b0;
      #1;
      n_chk++; if (state_out !== 3'd0) begin n_fail++; $display("FAIL midx_state: got %0d want 0", state_out); end
      n_chk++; if (we_reg_out !== 1'b0) begin n_fail++; $display("FAIL midx_we: got %b want 0", we_reg_out); end
      n_chk++; if (pc_sel_out !== 2'b11) begin n_fail++; $display("FAIL midx_pcsel: got %0d want 3", pc_sel_out); end
      n_chk++; if ({dr_out, sr1_out, imm5_out} !== 11'd0) begin n_fail++; $display("FAIL midx_fields: got %h want 0", {dr_out, sr1_out, imm5_out}); end
      @(posedge clka);
      #1;
      n_chk++; if (pc_latch_out !== 1'b0) begin n_fail++; $display("FAIL midx_latch: got %b want 0", pc_latch_out); end
      @(negedge clka);
      reset_in = 1'b1;
      @(negedge clka);
      n_chk++; if (state_out !== 3'd1) begin n_fail++; $display("FAIL midx_release: got %0d want 1", state_out); end
   endtask

   task automatic test_stall;
      bus.instr_valid_in = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clka);
         n_chk++; if (bus.instr_req_out !== 1'b1 || state_out !== 3'd1) begin
            n_fail++; $display("FAIL stall_%0d: got req=%b st=%0d want req=1 st=1", i, bus.instr_req_out, state_out); end
         n_chk++; if (pc_latch_out !== 1'b0 || pc_sel_out !== 2'b11 || we_reg_out !== 1'b0) begin
            n_fail++; $display("FAIL stall_out_%0d: got latch=%b sel=%0d we=%b want 0/3/0", i, pc_latch_out, pc_sel_out, we_reg_out); end
      end
   endtask

   task automatic test_add;
      run_instr(16'h12A3, 1'b0, 1'b0);
      n_chk++; if ({sn[1].we, sn[2].we, sn[3].we} !== 3'b010) begin n_fail++; $display("FAIL add_we: got %b want 010", {sn[1].we, sn[2].we, sn[3].we}); end
      n_chk++; if (sn[2].alu !== 2'b00) begin n_fail++; $display("FAIL add_alu: got %0d want 0", sn[2].alu); end
      n_chk++; if (sn[2].dr !== 3'd1 || sn[2].sr1 !== 3'd2) begin n_fail++; $display("FAIL add_regs: got dr=%0d sr1=%0d want 1/2", sn[2].dr, sn[2].sr1); end
      n_chk++; if (sn[2].isel !== 1'b1 || sn[2].imm5 !== 5'd3) begin n_fail++; $display("FAIL add_imm: got %b/%0d want 1/3", sn[2].isel, sn[2].imm5); end
      n_chk++; if (sn[3].psel !== 2'b00) begin n_fail++; $display("FAIL add_pcsel: got %0d want 0", sn[3].psel); end
      n_chk++; if ({sn[1].latch, sn[2].latch, sn[3].latch, sn[4].latch} !== 4'b0010) begin
         n_fail++; $display("FAIL add_latch: got %b want 0010", {sn[1].latch, sn[2].latch, sn[3].latch, sn[4].latch}); end
      n_chk++; if (sn[1].psel !== 2'b11 || sn[2].psel !== 2'b11 || sn[4].psel !== 2'b11) begin
         n_fail++; $display("FAIL add_hold: got %0d/%0d/%0d want 3/3/3", sn[1].psel, sn[2].psel, sn[4].psel); end
   endtask

   task automatic test_brz;
      run_instr(16'h0405, 1'b1, 1'b0);
      n_chk++; if ({sn[1].br, sn[2].br, sn[3].br, sn[4].br} !== 4'b0110) begin
         n_fail++; $display("FAIL brz_br: got %b want 0110", {sn[1].br, sn[2].br, sn[3].br, sn[4].br}); end
      n_chk++; if ({sn[2].n, sn[2].z, sn[2].p} !== 3'b010) begin n_fail++; $display("FAIL brz_nzp: got %b want 010", {sn[2].n, sn[2].z, sn[2].p}); end
      n_chk++; if (sn[2].off9 !== 9'd5) begin n_fail++; $display("FAIL brz_off9: got %0d want 5", sn[2].off9); end
      n_chk++; if (sn[3].psel !== 2'b01) begin n_fail++; $display("FAIL brz_taken: got %0d want 1", sn[3].psel); end
      run_instr(16'h0405, 1'b0, 1'b0);
      n_chk++; if (sn[3].psel !== 2'b00) begin n_fail++; $display("FAIL brz_not_taken: got %0d want 0", sn[3].psel); end
   endtask

   task automatic test_brnzp;
      run_instr(16'h0E00, 1'b0, 1'b0);
      n_chk++; if (sn[3].psel !== 2'b01) begin n_fail++; $display("FAIL brnzp_sel: got %0d want 1", sn[3].psel); end
      run_instr(16'h0000, 1'b1, 1'b0);
      n_chk++; if (sn[3].psel !== 2'b00) begin n_fail++; $display("FAIL brnone_sel: got %0d want 0", sn[3].psel); end
      n_chk++; if (sn[3].br !== 1'b1) begin n_fail++; $display("FAIL brnone_br: got %b want 1", sn[3].br); end
   endtask

   task automatic test_jmp;
      run_instr(16'hC0C0, 1'b0, 1'b0);
      n_chk++; if (sn[2].sr1 !== 3'd3) begin n_fail++; $display("FAIL jmp_sr1: got %0d want 3", sn[2].sr1); end
      n_chk++; if (sn[3].psel !== 2'b10) begin n_fail++; $display("FAIL jmp_sel: got %0d want 2", sn[3].psel); end
      n_chk++; if ({sn[1].we, sn[2].we, sn[3].we} !== 3'b000) begin n_fail++; $display("FAIL jmp_we: got %b want 000", {sn[1].we, sn[2].we, sn[3].we}); end
   endtask

   task automatic test_back_to_back;
      int ops [7] = '{0, 1, 5, 9, 12, 3, 13};
      for (int it = 0; it < 40; it++) begin
         int op, ins, e_psel;
         bit ctl, hold, alu_cls, e_br;
         op   = ops[$urandom_range(0, 6)];
         ins  = (op << 12) | int'($urandom_range(0, 4095));
         ctl  = 1'($urandom);
         hold = 1'($urandom);
         run_instr(16'(ins), ctl, hold);
         alu_cls = (op == 1 || op == 5 || op == 9);
         e_br    = (op == 0);
         e_psel  = exp_psel(ins, ctl);
         n_chk++; if ({sn[0].st, sn[1].st, sn[2].st, sn[3].st, sn[4].st} !== {3'd1, 3'd2, 3'd3, 3'd4, 3'd1}) begin
            n_fail++; $display("FAIL b2b_seq[%0d]: got %0d %0d %0d %0d %0d want 1 2 3 4 1", it, sn[0].st, sn[1].st, sn[2].st, sn[3].st, sn[4].st); end
         n_chk++; if ({sn[1].we, sn[2].we, sn[3].we} !== {1'b0, alu_cls, 1'b0}) begin
            n_fail++; $display("FAIL b2b_we[%0d] ins=%h: got %b want 0%b0", it, ins, {sn[1].we, sn[2].we, sn[3].we}, alu_cls); end
         n_chk++; if (int'(sn[3].psel) != e_psel || sn[3].latch !== 1'b1) begin
            n_fail++; $display("FAIL b2b_pc[%0d] ins=%h ctl=%b: got sel=%0d latch=%b want sel=%0d latch=1", it, ins, ctl, sn[3].psel, sn[3].latch, e_psel); end
         n_chk++; if ({sn[2].br, sn[3].br} !== {e_br, e_br}) begin
            n_fail++; $display("FAIL b2b_br[%0d] ins=%h: got %b%b want %b%b", it, ins, sn[2].br, sn[3].br, e_br, e_br); end
         if (e_br) begin
            n_chk++; if ({sn[3].n, sn[3].z, sn[3].p} !== 3'((ins >> 9) & 7) || int'(sn[3].off9) != (ins & 511)) begin
               n_fail++; $display("FAIL b2b_brf[%0d] ins=%h: got nzp=%b off=%0d", it, ins, {sn[3].n, sn[3].z, sn[3].p}, sn[3].off9); end
         end
         if (op == 1 || op == 5) begin
            n_chk++; if (int'(sn[2].dr) != ((ins >> 9) & 7) || int'(sn[2].sr1) != ((ins >> 6) & 7) ||
                         int'(sn[3].sr2) != (ins & 7) || int'(sn[3].imm5) != (ins & 31) ||
                         int'(sn[3].isel) != ((ins >> 5) & 1) || int'(sn[2].alu) != (op == 5 ? 1 : 0)) begin
               n_fail++; $display("FAIL b2b_alu[%0d] ins=%h: got dr=%0d sr1=%0d sr2=%0d imm=%0d isel=%b alu=%0d",
                                  it, ins, sn[2].dr, sn[2].sr1, sn[3].sr2, sn[3].imm5, sn[3].isel, sn[2].alu); end
         end
         if (op == 9) begin
            n_chk++; if (sn[2].alu !== 2'b10) begin n_fail++; $display("FAIL b2b_not[%0d]: got alu=%0d want 2", it, sn[2].alu); end
         end
         if (op == 12) begin
            n_chk++; if (int'(sn[3].sr1) != ((ins >> 6) & 7)) begin n_fail++; $display("FAIL b2b_jmp[%0d]: got sr1=%0d", it, sn[3].sr1); end
         end
      end
   endtask

   task automatic test_halt;
      run_instr(16'hF025, 1'b0, 1'b0);
      n_chk++; if (sn[3].psel !== 2'b00 || sn[3].latch !== 1'b1) begin
         n_fail++; $display("FAIL trap_pc: got sel=%0d latch=%b want 0/1", sn[3].psel, sn[3].latch); end
      bus.instr_valid_in = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clka);
         n_chk++; if (state_out !== 3'd5 || halt_out !== 1'b1 || bus.instr_req_out !== 1'b0) begin
            n_fail++; $display("FAIL halt_%0d: got st=%0d halt=%b req=%b want 5/1/0", i, state_out, halt_out, bus.instr_req_out); end
         n_chk++; if ({pc_latch_out, we_reg_out, br_out} !== 3'b000) begin
            n_fail++; $display("FAIL halt_ctl_%0d: got %b want 000", i, {pc_latch_out, we_reg_out, br_out}); end
      end
      bus.instr_valid_in = 1'b0;
   endtask

   initial begin
      test_reset();
      test_reset_mid_exec();
      test_stall();
      test_add();
      test_brz();
      test_brnzp();
      test_jmp();
      test_back_to_back();
      test_halt();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/instr_seq.md
INSTR_SEQ -- requirements
Module: instr_seq

Interface
REQ-001 Parameter: INSTR_W, 16, instruction word width; only 16 is supported.
REQ-002 clka  in  1  single system clock; all state updates on rising edge.
REQ-003 reset_in  in  1  asynchronous, active-low reset.
REQ-004 instr_in  in  INSTR_W  instruction word from instruction memory.
REQ-005 instr_valid_in  in  1  instr_in valid this cycle.
REQ-006 instr_req_out  out  1  fetch request to instruction memory.
REQ-007 pc_ctl_0_in  in  1  branch-taken indication from condition-code FSM.
REQ-008 pc_sel_out  out  2  PC source: 00 increment, 01 PC+offset9, 10 register (sr1), 11 hold.
REQ-009 pc_latch_out  out  1  one-cycle PC update strobe.
REQ-010 we_reg_out  out  1  register write / condition-code update enable.
REQ-011 br_out, n_dec_out, z_dec_out, p_dec_out  out  1 each  branch request and instruction nzp bits to the condition-code FSM.
REQ-012 alu_op_out  out  2  00 ADD, 01 AND, 10 NOT, 11 PASS.
REQ-013 dr_out, sr1_out, sr2_out  out  3 each  register addresses.
REQ-014 imm_sel_out  out  1; imm5_out  out  5; offset9_out  out  9  immediate operands, raw instruction fields.
REQ-015 halt_out  out  1  processor halted.
REQ-016 state_out  out  3  current state encoding.

Function
REQ-017 States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, PCUPD=4, HALT=5; encodings 6–7 are unreachable and go to IDLE.
REQ-018 IDLE goes to FETCH on the first clka edge after reset_in deasserts.
REQ-019 FETCH holds instr_req_out=1; it registers instr_in and goes to DECODE on the edge where instr_valid_in=1, and otherwise remains in FETCH with all other outputs unchanged.
REQ-020 instr_valid_in outside FETCH is ignored.
REQ-021 DECODE drives the register, immediate and alu_op fields from the registered instruction; these fields are held through EXEC and PCUPD.
- ADD=0001, AND=0101: dr=[11:9], sr1=[8:6], imm_sel=[5], imm5=[4:0], sr2=[2:0].
- NOT=1001: alu_op=NOT.
- BR=0000: nzp=[11:9], offset9=[8:0].
- JMP=1100: sr1=[8:6].
- TRAP=1111: enters HALT after PCUPD.
- Other opcodes: NOP.
REQ-022 EXEC asserts we_reg_out for exactly one cycle for ADD, AND and NOT only.
REQ-023 For BR, br_out and n/z/p_dec_out are asserted in EXEC and held through PCUPD; they are 0 in all other states and for non-BR instructions.
REQ-024 PCUPD samples pc_ctl_0_in and pulses pc_latch_out for one cycle with pc_sel_out selected as follows:
- BR with nzp=111: 01, regardless of pc_ctl_0_in.
- BR with nzp=000: 00.
- Other BR: 01 if pc_ctl_0_in=1, else 00.
- JMP: 10.
- All others: 00.
REQ-025 PCUPD goes to FETCH, or to HALT for TRAP.
REQ-026 pc_latch_out rises exactly 3 clka cycles after the instr_valid_in acceptance edge.
REQ-027 Outside PCUPD, pc_sel_out=11.
REQ-028 HALT is sticky until reset: halt_out=1, instr_req_out=0, pc_latch_out=0, we_reg_out=0, br_out=0.

Reset
REQ-029 reset_in=0 forces IDLE immediately, independent of clka, from any state including mid-EXEC or mid-PCUPD.
REQ-030 During reset, all outputs are 0 except pc_sel_out=11, and the instruction register is 0.
REQ-031 An aborted instruction produces no we_reg_out or pc_latch_out pulse.

Structure
REQ-032 Shared package instr_seq_pkg holds: opcode constants, state encoding, pc_sel codes and alu_op codes.
REQ-033 One combinational sub-module, instr_decode, maps the instruction register to fields and opcode class; all sequencing stays in instr_seq.

Verification
REQ-034 Reset test: reset_in=0 during EXEC -> outputs clear asynchronously, state_out=0; after release -> state_out=1 one edge later.
REQ-035 ADD test: instr_in=0x12A3 -> EXEC has we_reg_out=1 for one cycle, alu_op=00, dr=1, sr1=2, imm_sel=1, imm5=3; PCUPD has pc_sel=00 and a pc_latch_out pulse 3 cycles after acceptance.
REQ-036 BRz test: instr_in=0x0405 -> br_out=1, z_dec=1, n_dec=p_dec=0, offset9=5; pc_ctl_0_in=1 gives pc_sel=01, and a repeat with pc_ctl_0_in=0 gives pc_sel=00.
REQ-037 BRnzp test: instr_in=0x0E00 with pc_ctl_0_in=0 -> pc_sel=01; instr_in=0x0000 -> pc_sel=00 and br_out=1.
REQ-038 JMP test: instr_in=0xC0C0 -> sr1=3, pc_sel=10, we_reg_out=0.
REQ-039 Stall test: instr_valid_in low for 4 cycles -> instr_req_out held at 1 with no state change.
REQ-040 Halt test: instr_in=0xF025 -> state_out=5, halt_out=1, instr_req_out=0 for 10 cycles while instr_valid_in=1.
